// File: rtl/mem_pkg.sv
// Shared encodings for the memory stage: funct3 access widths, writeback select, FSM states.
// Also holds the store byte-enable rule so lane logic lives in one place.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;
  localparam logic [1:0] RES_IMM  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mem_state_t;

  // Half-word stores ignore lo[0]; anything other than B/H is a full word.
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_B:    store_be = 4'b0001 << lo;
      F3_H:    store_be = lo[1] ? 4'b1100 : 4'b0011;
      default: store_be = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory req/ack bus: one outstanding request, ack is a one-cycle pulse with rdata valid.
// Request side holds all fields stable until ack.
interface mem_stage_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 17
);
  logic                      memReq;
  logic                      memWe;
  logic [MEM_ADDR_WIDTH-1:0] memAddr;
  logic [3:0]                memBe;
  logic [DATA_WIDTH-1:0]     memWdata;
  logic [DATA_WIDTH-1:0]     memRdata;
  logic                      memAck;

  modport master (
    output memReq, memWe, memAddr, memBe, memWdata,
    input  memRdata, memAck
  );

  modport slave (
    input  memReq, memWe, memAddr, memBe, memWdata,
    output memRdata, memAck
  );
endinterface

// File: rtl/load_align.sv
// Load lane select and sign/zero extension; purely combinational.
// Unknown funct3 codes fall through to a full-word load.
module load_align
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            lo,
  input  logic [2:0]            ctrl,
  output logic [DATA_WIDTH-1:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    case (lo)
      2'd0:    lane_b = rdata[7:0];
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      default: lane_b = rdata[31:24];
    endcase
    lane_h = lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    case (ctrl)
      F3_B:    data = {{(DATA_WIDTH-8){lane_b[7]}}, lane_b};
      F3_BU:   data = {{(DATA_WIDTH-8){1'b0}}, lane_b};
      F3_H:    data = {{(DATA_WIDTH-16){lane_h[15]}}, lane_h};
      F3_HU:   data = {{(DATA_WIDTH-16){1'b0}}, lane_h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32 memory stage: issues one req/ack access per load/store and fills the M/W register.
// Memory ops take 3 cycles plus ack wait; stallM freezes execute until the DONE cycle.
module mem_stage
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ROM_WIDTH      = 12,
  parameter int RF_WIDTH       = 5,
  parameter int MEM_ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  regWriteM,
  input  logic                  memWriteM,
  input  logic [1:0]            resultSelM,
  input  logic [2:0]            memCtrlM,
  input  logic [DATA_WIDTH-1:0] aluResultM,
  input  logic [DATA_WIDTH-1:0] memDinM,
  input  logic [RF_WIDTH-1:0]   regAddr3M,
  input  logic [ROM_WIDTH-1:0]  pcM,
  input  logic [DATA_WIDTH-1:0] immExtM,
  mem_stage_if.master           mem_bus,
  output logic                  stallM,
  output logic                  regWriteW,
  output logic [1:0]            resultSelW,
  output logic [DATA_WIDTH-1:0] aluResultW,
  output logic [DATA_WIDTH-1:0] readDataW,
  output logic [DATA_WIDTH-1:0] immExtW,
  output logic [RF_WIDTH-1:0]   regAddr3W,
  output logic [ROM_WIDTH-1:0]  pcW
);

  mem_state_t state, state_nx;
  logic       mem_op;
  logic       start;
  logic       finish;

  logic                      req_q;
  logic                      we_q;
  logic [MEM_ADDR_WIDTH-1:0] addr_q;
  logic [3:0]                be_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [1:0]                lo_q;
  logic [2:0]                ctrl_q;
  logic [DATA_WIDTH-1:0]     hold_q;
  logic [DATA_WIDTH-1:0]     store_data;
  logic [DATA_WIDTH-1:0]     load_data;

  assign mem_op = memWriteM | (resultSelM == RES_LOAD);
  assign stallM = mem_op & (state != ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    finish   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mem_op) begin
          state_nx = ST_BUSY;
          start    = 1'b1;
        end
      end
      ST_BUSY: begin
        if (mem_bus.memAck) begin
          state_nx = ST_DONE;
          finish   = 1'b1;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    case (memCtrlM)
      F3_B:    store_data = {4{memDinM[7:0]}};
      F3_H:    store_data = {2{memDinM[15:0]}};
      default: store_data = memDinM;
    endcase
  end

  // Lane info is captured with the request so alignment never depends on M inputs after issue.
  load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
    .rdata (mem_bus.memRdata),
    .lo    (lo_q),
    .ctrl  (ctrl_q),
    .data  (load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
      ctrl_q  <= '0;
      hold_q  <= '0;
    end else if (start) begin
      req_q   <= 1'b1;
      we_q    <= memWriteM;
      addr_q  <= {aluResultM[MEM_ADDR_WIDTH-1:2], 2'b00};
      be_q    <= memWriteM ? store_be(memCtrlM, aluResultM[1:0]) : 4'b1111;
      wdata_q <= store_data;
      lo_q    <= aluResultM[1:0];
      ctrl_q  <= memCtrlM;
    end else if (finish) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      hold_q  <= load_data;
    end
  end

  assign mem_bus.memReq   = req_q;
  assign mem_bus.memWe    = we_q;
  assign mem_bus.memAddr  = addr_q;
  assign mem_bus.memBe    = be_q;
  assign mem_bus.memWdata = wdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regWriteW  <= 1'b0;
      resultSelW <= '0;
      aluResultW <= '0;
      readDataW  <= '0;
      immExtW    <= '0;
      regAddr3W  <= '0;
      pcW        <= '0;
    end else if (!stallM) begin
      regWriteW  <= regWriteM;
      resultSelW <= resultSelM;
      aluResultW <= aluResultM;
      readDataW  <= hold_q;
      immExtW    <= immExtM;
      regAddr3W  <= regAddr3M;
      pcW        <= pcM;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, reset-abort sequence, and random ops against a lane-rule model.
module tb_mem_stage;
  import mem_pkg::*;

  typedef struct {
    logic        rw, we;
    logic [1:0]  rs;
    logic [2:0]  ctrl;
    logic [31:0] alu, din, imm;
    logic [4:0]  rd;
    logic [11:0] pc;
  } instr_t;

  typedef struct {
    int          stall;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [16:0] addr;
    logic [31:0] rd;
    bit          chk_wd, chk_rd;
  } exp_t;

  typedef struct {
    instr_t      ins;
    logic [31:0] rdata;
    int          lat;
    exp_t        e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        regWriteM, memWriteM;
  logic [1:0]  resultSelM;
  logic [2:0]  memCtrlM;
  logic [31:0] aluResultM, memDinM, immExtM;
  logic [4:0]  regAddr3M;
  logic [11:0] pcM;
  logic        stallM, regWriteW;
  logic [1:0]  resultSelW;
  logic [31:0] aluResultW, readDataW, immExtW;
  logic [4:0]  regAddr3W;
  logic [11:0] pcW;

  mem_stage_if #(.DATA_WIDTH(32), .MEM_ADDR_WIDTH(17)) mb ();

  mem_stage #(.DATA_WIDTH(32), .ROM_WIDTH(12), .RF_WIDTH(5), .MEM_ADDR_WIDTH(17)) dut (
    .clk(clk), .rst(rst),
    .regWriteM(regWriteM), .memWriteM(memWriteM), .resultSelM(resultSelM), .memCtrlM(memCtrlM),
    .aluResultM(aluResultM), .memDinM(memDinM), .regAddr3M(regAddr3M), .pcM(pcM), .immExtM(immExtM),
    .mem_bus(mb), .stallM(stallM),
    .regWriteW(regWriteW), .resultSelW(resultSelW), .aluResultW(aluResultW), .readDataW(readDataW),
    .immExtW(immExtW), .regAddr3W(regAddr3W), .pcW(pcW)
  );

  int    n_chk  = 0;
  int    n_fail = 0;
  string tag    = "reset";
  vec_t  vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got 0x%08h, expected 0x%08h", tag, name, act, exp);
    end
  endtask

  function automatic instr_t ins_f(input logic rw, we, input logic [1:0] rs, input logic [2:0] ctrl,
                                   input logic [31:0] alu, din, imm, input logic [4:0] rd,
                                   input logic [11:0] pc);
    instr_t i;
    i.rw = rw; i.we = we; i.rs = rs; i.ctrl = ctrl; i.alu = alu; i.din = din;
    i.imm = imm; i.rd = rd; i.pc = pc;
    return i;
  endfunction

  function automatic exp_t exp_f(input int stall, input logic [3:0] be, input logic [31:0] wdata,
                                 input logic [16:0] addr, input logic [31:0] rd,
                                 input bit chk_wd, chk_rd);
    exp_t e;
    e.stall = stall; e.be = be; e.wdata = wdata; e.addr = addr; e.rd = rd;
    e.chk_wd = chk_wd; e.chk_rd = chk_rd;
    return e;
  endfunction

  task automatic add_vec(input instr_t i, input logic [31:0] rdata, input int lat, input exp_t e);
    vec_t v;
    v.ins = i; v.rdata = rdata; v.lat = lat; v.e = e;
    vecs.push_back(v);
  endtask

  // Reference: byte/half lanes by address arithmetic, extension by subtracting 2^w.
  function automatic exp_t model(input instr_t i, input logic [31:0] rdata, input int lat);
    exp_t   e;
    int     a, sh, w;
    longint v;
    bit     mem, sgn;
    a      = int'(i.alu & 32'd3);
    mem    = i.we || (i.rs == 2'b01);
    e.stall  = mem ? lat + 1 : 0;
    e.addr   = 17'(i.alu & 32'h1FFFC);
    e.chk_wd = i.we;
    e.chk_rd = mem && !i.we;
    if (!i.we)                 begin e.be = 4'hF; e.wdata = 32'd0; end
    else if (i.ctrl == 3'b000) begin e.be = 4'(1 << a); e.wdata = (i.din & 32'hFF) * 32'h01010101; end
    else if (i.ctrl == 3'b001) begin e.be = (a >= 2) ? 4'hC : 4'h3; e.wdata = (i.din & 32'hFFFF) * 32'h00010001; end
    else                       begin e.be = 4'hF; e.wdata = i.din; end
    w = 32; sh = 0;
    if (i.ctrl == 3'b000 || i.ctrl == 3'b100)      begin w = 8;  sh = 8 * a; end
    else if (i.ctrl == 3'b001 || i.ctrl == 3'b101) begin w = 16; sh = 16 * (a / 2); end
    sgn = (i.ctrl == 3'b000) || (i.ctrl == 3'b001);
    v = (longint'(rdata) >> sh) & ((longint'(1) << w) - 1);
    if (sgn && v >= (longint'(1) << (w - 1))) v = v - (longint'(1) << w);
    e.rd = 32'(v);
    return e;
  endfunction

  task automatic apply(input instr_t i);
    regWriteM = i.rw; memWriteM = i.we; resultSelM = i.rs; memCtrlM = i.ctrl;
    aluResultM = i.alu; memDinM = i.din; immExtM = i.imm; regAddr3M = i.rd; pcM = i.pc;
  endtask

  // Entered at posedge+1; returns at posedge+1 after the edge where W captured the instruction.
  task automatic run_instr(input instr_t i, input logic [31:0] rdata, input int lat, input exp_t e);
    int stalls = 0, reqs = 0, busy = 0;
    bit prev_req = 0, done = 0, st;
    bit mem = i.we || (i.rs == 2'b01);
    apply(i);
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      mb.memAck = 1'b0;
      if (mb.memReq) begin
        if (!prev_req) reqs++;
        busy++;
        chk("memAddr", 32'(mb.memAddr), 32'(e.addr));
        chk("memBe", 32'(mb.memBe), 32'(e.be));
        chk("memWe", 32'(mb.memWe), 32'(i.we));
        if (e.chk_wd) chk("memWdata", mb.memWdata, e.wdata);
        mb.memAck   = (busy == lat);
        mb.memRdata = (busy == lat) ? rdata : $urandom;
      end
      prev_req = mb.memReq;
      @(negedge clk);
      st = stallM;
      if (st) stalls++;
      @(posedge clk); #1;
      if (!st) done = 1;
    end
    mb.memAck = 1'b0;
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL %s/timeout: instruction never retired within 40 cycles", tag);
    end
    chk("stall_cycles", 32'(stalls), 32'(e.stall));
    chk("req_count", 32'(reqs), mem ? 32'd1 : 32'd0);
    chk("busy_cycles", 32'(busy), mem ? 32'(lat) : 32'd0);
    chk("regWriteW", 32'(regWriteW), 32'(i.rw));
    chk("resultSelW", 32'(resultSelW), 32'(i.rs));
    chk("aluResultW", aluResultW, i.alu);
    chk("immExtW", immExtW, i.imm);
    chk("regAddr3W", 32'(regAddr3W), 32'(i.rd));
    chk("pcW", 32'(pcW), 32'(i.pc));
    if (e.chk_rd) chk("readDataW", readDataW, e.rd);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    instr_t zero;
    zero = ins_f(0, 0, 2'b00, 3'b000, 32'd0, 32'd0, 32'd0, 5'd0, 12'd0);
    apply(zero);
    mb.memAck = 1'b0; mb.memRdata = 32'd0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("memReq", 32'(mb.memReq), 0);     chk("memWe", 32'(mb.memWe), 0);
    chk("memBe", 32'(mb.memBe), 0);       chk("memAddr", 32'(mb.memAddr), 0);
    chk("memWdata", mb.memWdata, 0);      chk("stallM", 32'(stallM), 0);
    chk("regWriteW", 32'(regWriteW), 0);  chk("resultSelW", 32'(resultSelW), 0);
    chk("aluResultW", aluResultW, 0);     chk("readDataW", readDataW, 0);
    chk("immExtW", immExtW, 0);           chk("regAddr3W", 32'(regAddr3W), 0);
    chk("pcW", 32'(pcW), 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    add_vec(ins_f(1, 0, 2'b00, 3'b000, 32'h1234, 0, 0, 5'd5, 12'h010), 0, 1, exp_f(0, 0, 0, 0, 0, 0, 0));
    add_vec(ins_f(1, 0, 2'b01, 3'b000, 32'h103, 0, 0, 5'd6, 12'h014), 32'h80FF_FF00, 1,
            exp_f(2, 4'hF, 0, 17'h100, 32'hFFFF_FF80, 0, 1));
    add_vec(ins_f(1, 0, 2'b01, 3'b101, 32'h102, 0, 0, 5'd7, 12'h018), 32'hBEEF_0000, 1,
            exp_f(2, 4'hF, 0, 17'h100, 32'h0000_BEEF, 0, 1));
    add_vec(ins_f(1, 0, 2'b01, 3'b001, 32'h102, 0, 0, 5'd8, 12'h01C), 32'hBEEF_0000, 1,
            exp_f(2, 4'hF, 0, 17'h100, 32'hFFFF_BEEF, 0, 1));
    add_vec(ins_f(0, 1, 2'b00, 3'b000, 32'h201, 32'h1234_56AB, 0, 5'd0, 12'h020), 0, 1,
            exp_f(2, 4'b0010, 32'hABAB_ABAB, 17'h200, 0, 1, 0));
    add_vec(ins_f(1, 0, 2'b01, 3'b010, 32'h3F0, 0, 0, 5'd9, 12'h024), 32'h1234_5678, 4,
            exp_f(5, 4'hF, 0, 17'h3F0, 32'h1234_5678, 0, 1));
    add_vec(ins_f(0, 1, 2'b00, 3'b010, 32'h406, 32'hDEAD_BEEF, 0, 5'd0, 12'h028), 0, 1,
            exp_f(2, 4'hF, 32'hDEAD_BEEF, 17'h404, 0, 1, 0));
    add_vec(ins_f(0, 1, 2'b00, 3'b001, 32'h207, 32'h1234_CAFE, 0, 5'd0, 12'h02C), 0, 2,
            exp_f(3, 4'b1100, 32'hCAFE_CAFE, 17'h204, 0, 1, 0));
    add_vec(ins_f(0, 1, 2'b00, 3'b000, 32'h300, 32'h0000_005A, 0, 5'd0, 12'h030), 0, 1,
            exp_f(2, 4'b0001, 32'h5A5A_5A5A, 17'h300, 0, 1, 0));
    add_vec(ins_f(1, 0, 2'b01, 3'b100, 32'h101, 0, 0, 5'd10, 12'h034), 32'h0000_8000, 1,
            exp_f(2, 4'hF, 0, 17'h100, 32'h0000_0080, 0, 1));
    add_vec(ins_f(1, 0, 2'b01, 3'b011, 32'h7, 0, 0, 5'd11, 12'h038), 32'hA5A5_0001, 1,
            exp_f(2, 4'hF, 0, 17'h004, 32'hA5A5_0001, 0, 1));
    add_vec(ins_f(1, 0, 2'b01, 3'b110, 32'hFFFF_FFFF, 0, 0, 5'd12, 12'h03C), 32'hCAFE_F00D, 3,
            exp_f(4, 4'hF, 0, 17'h1FFFC, 32'hCAFE_F00D, 0, 1));
    add_vec(ins_f(1, 0, 2'b11, 3'b000, 32'h55, 0, 32'hFFFF_F000, 5'd13, 12'h123), 0, 1, exp_f(0, 0, 0, 0, 0, 0, 0));
    add_vec(ins_f(1, 0, 2'b10, 3'b010, 32'h66, 0, 32'h0000_0004, 5'd31, 12'hFFF), 0, 1, exp_f(0, 0, 0, 0, 0, 0, 0));

    foreach (vecs[k]) begin
      tag = $sformatf("vec%0d", k);
      run_instr(vecs[k].ins, vecs[k].rdata, vecs[k].lat, vecs[k].e);
    end

    tag = "rst_busy";
    apply(ins_f(1, 0, 2'b01, 3'b010, 32'h500, 0, 0, 5'd9, 12'h200));
    @(posedge clk); #1;
    chk("memReq_issued", 32'(mb.memReq), 1);
    @(posedge clk); #3;
    rst = 1'b1; #1;
    chk("memReq", 32'(mb.memReq), 0);     chk("memWe", 32'(mb.memWe), 0);
    chk("memBe", 32'(mb.memBe), 0);       chk("memAddr", 32'(mb.memAddr), 0);
    chk("memWdata", mb.memWdata, 0);      chk("regWriteW", 32'(regWriteW), 0);
    chk("aluResultW", aluResultW, 0);     chk("pcW", 32'(pcW), 0);
    chk("regAddr3W", 32'(regAddr3W), 0);  chk("immExtW", immExtW, 0);
    apply(zero); #1;
    chk("stallM", 32'(stallM), 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    mb.memAck = 1'b1; mb.memRdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mb.memAck = 1'b0;
    chk("late_ack_memReq", 32'(mb.memReq), 0);
    chk("late_ack_stallM", 32'(stallM), 0);
    @(posedge clk); #1;
    chk("late_ack_readDataW", readDataW, 0);
    chk("late_ack_memReq2", 32'(mb.memReq), 0);

    for (int n = 0; n < 150; n++) begin
      instr_t      i;
      logic [31:0] rdata;
      int          lat, kind;
      kind  = $urandom_range(0, 2);
      lat   = $urandom_range(1, 4);
      rdata = $urandom;
      i = ins_f(1'($urandom), 0, 2'b00, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                5'($urandom), 12'($urandom));
      if (kind == 0) begin
        i.rs = 2'($urandom_range(0, 2));
        if (i.rs == 2'b01) i.rs = 2'b11;
      end else if (kind == 1) begin
        i.rs = 2'b01;
      end else begin
        i.we = 1'b1;
      end
      tag = $sformatf("rand%0d", n);
      run_instr(i, rdata, lat, model(i, rdata, lat));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
